// File: rtl/pixel_write_combiner.sv
// Merges byte-wide draw-engine writes into 32-bit word writes queued to the frame store.
// Optional COMBINER_STATS_EN adds stat_in/stat_out transfer counters.
module pixel_write_combiner #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_req,
  output logic        de_ack,
  input  logic [17:0] de_addr,
  input  logic [3:0]  de_nbyte,
  input  logic        de_rnw,
  input  logic [31:0] de_w_data,
  output logic [31:0] de_r_data,
  input  logic        flush,
  output logic        idle,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [17:0] mem_addr,
  output logic [3:0]  mem_nbyte,
  output logic        mem_rnw,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
`ifdef COMBINER_STATS_EN
  ,
  output logic [15:0] stat_in,
  output logic [15:0] stat_out
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ} mstate_e;

  mstate_e     state_q, state_d;

  logic        cmb_valid_q, cmb_valid_d;
  logic [17:0] cmb_addr_q, cmb_addr_d;
  logic [3:0]  cmb_nbyte_q, cmb_nbyte_d;
  logic [31:0] cmb_data_q, cmb_data_d;
  logic [7:0]  tmo_q, tmo_d;

  logic        rd_pend_q, rd_pend_d;
  logic        rd_ack_q, rd_ack_d;
  logic [31:0] de_r_data_q, de_r_data_d;
  logic        idle_q, idle_d;

  logic        mem_req_q, mem_req_d;
  logic [17:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_nbyte_q, mem_nbyte_d;
  logic        mem_rnw_q, mem_rnw_d;
  logic [31:0] mem_w_data_q, mem_w_data_d;

  logic [17:0] fifo_addr  [DEPTH];
  logic [3:0]  fifo_nbyte [DEPTH];
  logic [31:0] fifo_data  [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;

  logic fifo_full, fifo_empty;
  logic addr_match, wr_acc, retire_cond, push, pop;
  logic [31:0] merged_data;

  assign fifo_full  = (count_q == (AW+1)'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign addr_match = cmb_valid_q && (cmb_addr_q == de_addr);

  // Write acceptance is combinational so a stream of hits to the open word never stalls.
  assign wr_acc = de_req && !de_rnw && !rd_pend_q &&
                  (!cmb_valid_q || addr_match || !fifo_full);

  assign retire_cond = (cmb_nbyte_q == 4'h0) || (tmo_q == 8'(TIMEOUT)) ||
                       flush || rd_pend_q;

  always_comb begin
    merged_data = cmb_data_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!de_nbyte[i]) merged_data[8*i +: 8] = de_w_data[8*i +: 8];
    end
  end

  // Combiner: accept (load / merge / evict+load) has priority; retire only on idle cycles.
  always_comb begin
    cmb_valid_d = cmb_valid_q;
    cmb_addr_d  = cmb_addr_q;
    cmb_nbyte_d = cmb_nbyte_q;
    cmb_data_d  = cmb_data_q;
    tmo_d       = tmo_q;
    push        = 1'b0;
    if (wr_acc) begin
      tmo_d = '0;
      if (addr_match) begin
        cmb_nbyte_d = cmb_nbyte_q & de_nbyte;
        cmb_data_d  = merged_data;
      end else begin
        push        = cmb_valid_q;
        cmb_valid_d = 1'b1;
        cmb_addr_d  = de_addr;
        cmb_nbyte_d = de_nbyte;
        cmb_data_d  = de_w_data;
      end
    end else if (cmb_valid_q) begin
      if (retire_cond && !fifo_full) begin
        push        = 1'b1;
        cmb_valid_d = 1'b0;
        tmo_d       = '0;
      end else if (tmo_q != 8'(TIMEOUT)) begin
        tmo_d = tmo_q + 8'd1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rd_pend_d = rd_pend_q;
    if (rd_ack_q) rd_pend_d = 1'b0;
    else if (de_req && de_rnw) rd_pend_d = 1'b1;
  end

  assign idle_d = !cmb_valid_q && fifo_empty && (state_q == M_IDLE);

  // Memory FSM: buffered writes drain before any read is issued.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_nbyte_d  = mem_nbyte_q;
    mem_rnw_d    = mem_rnw_q;
    mem_w_data_d = mem_w_data_q;
    de_r_data_d  = de_r_data_q;
    rd_ack_d     = 1'b0;
    pop          = 1'b0;
    case (state_q)
      M_IDLE: begin
        if (!fifo_empty) begin
          state_d      = M_WRITE;
          mem_req_d    = 1'b1;
          mem_rnw_d    = 1'b0;
          mem_addr_d   = fifo_addr[rd_ptr_q];
          mem_nbyte_d  = fifo_nbyte[rd_ptr_q];
          mem_w_data_d = fifo_data[rd_ptr_q];
        end else if (rd_pend_q && !cmb_valid_q && !rd_ack_q) begin
          state_d     = M_READ;
          mem_req_d   = 1'b1;
          mem_rnw_d   = 1'b1;
          mem_nbyte_d = 4'h0;
          mem_addr_d  = de_addr;
        end
      end
      M_WRITE: begin
        if (mem_ack) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          state_d   = M_IDLE;
        end
      end
      M_READ: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          de_r_data_d = mem_r_data;
          rd_ack_d    = 1'b1;
          state_d     = M_IDLE;
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= M_IDLE;
      cmb_valid_q  <= 1'b0;
      cmb_addr_q   <= '0;
      cmb_nbyte_q  <= '1;
      cmb_data_q   <= '0;
      tmo_q        <= '0;
      rd_pend_q    <= 1'b0;
      rd_ack_q     <= 1'b0;
      de_r_data_q  <= '0;
      idle_q       <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_nbyte_q  <= '1;
      mem_rnw_q    <= 1'b0;
      mem_w_data_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cmb_valid_q  <= cmb_valid_d;
      cmb_addr_q   <= cmb_addr_d;
      cmb_nbyte_q  <= cmb_nbyte_d;
      cmb_data_q   <= cmb_data_d;
      tmo_q        <= tmo_d;
      rd_pend_q    <= rd_pend_d;
      rd_ack_q     <= rd_ack_d;
      de_r_data_q  <= de_r_data_d;
      idle_q       <= idle_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_nbyte_q  <= mem_nbyte_d;
      mem_rnw_q    <= mem_rnw_d;
      mem_w_data_q <= mem_w_data_d;
      count_q      <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q]  <= cmb_addr_q;
      fifo_nbyte[wr_ptr_q] <= cmb_nbyte_q;
      fifo_data[wr_ptr_q]  <= cmb_data_q;
    end
  end

`ifdef COMBINER_STATS_EN
  logic [15:0] stat_in_q, stat_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_in_q  <= '0;
      stat_out_q <= '0;
    end else begin
      if (wr_acc) stat_in_q  <= stat_in_q + 16'd1;
      if (pop)    stat_out_q <= stat_out_q + 16'd1;
    end
  end

  assign stat_in  = stat_in_q;
  assign stat_out = stat_out_q;
`endif

  assign de_ack     = rd_ack_q || wr_acc;
  assign de_r_data  = de_r_data_q;
  assign idle       = idle_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_nbyte  = mem_nbyte_q;
  assign mem_rnw    = mem_rnw_q;
  assign mem_w_data = mem_w_data_q;

endmodule

// File: tb/tb_pixel_write_combiner.sv
// Scoreboard bench for pixel_write_combiner: expected memory transactions and read
// data are queued by the stimulus and checked by the memory-side and upstream monitors.
module tb_pixel_write_combiner;

  typedef struct {
    logic        rnw;
    logic [17:0] addr;
    logic [3:0]  nbyte;
    logic [31:0] data;
  } mtx_t;

  logic        clk, rst_n;
  logic        de_req, de_ack, de_rnw, flush, idle;
  logic [17:0] de_addr, mem_addr;
  logic [3:0]  de_nbyte, mem_nbyte;
  logic [31:0] de_w_data, de_r_data, mem_w_data, mem_r_data;
  logic        mem_req, mem_ack, mem_rnw;

  logic        ack_en;
  int          n_cmp, n_err, n_rdack;
  mtx_t        expq[$];
  logic [31:0] rdq[$];

  pixel_write_combiner #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
    .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data),
    .flush(flush), .idle(idle),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_nbyte(mem_nbyte),
    .mem_rnw(mem_rnw), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [17:0] a);
    return {14'h0, a} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [17:0] a, input logic [3:0] nb, input logic [31:0] d);
    mtx_t t;
    t.rnw = 1'b0; t.addr = a; t.nbyte = nb; t.data = d;
    expq.push_back(t);
  endtask

  // Memory responder and scoreboard: zero-wait ack, checks every issued transaction.
  initial begin
    mtx_t e;
    mem_ack = 1'b0;
    mem_r_data = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req && ack_en && rst_n) begin
        if (expq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_mem_txn: got addr=%h rnw=%b nbyte=%b expected none",
                   mem_addr, mem_rnw, mem_nbyte);
        end else begin
          e = expq.pop_front();
          check("mem_rnw", 32'(mem_rnw), 32'(e.rnw));
          check("mem_addr", 32'(mem_addr), 32'(e.addr));
          check("mem_nbyte", 32'(mem_nbyte), 32'(e.nbyte));
          if (!e.rnw) check("mem_w_data", mem_w_data, e.data);
        end
        if (mem_rnw) mem_r_data = mem_model(mem_addr);
        mem_ack = 1'b1;
      end
    end
  end

  // Upstream read-return monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (de_req && de_rnw && de_ack) begin
        n_rdack++;
        if (rdq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_rd_ack: got %h expected none", de_r_data);
        end else begin
          check("de_r_data", de_r_data, rdq.pop_front());
        end
      end
    end
  end

  task automatic xfer(input logic rnw, input logic [17:0] a, input logic [3:0] nb,
                      input logic [31:0] d);
    bit got = 0;
    de_req = 1'b1; de_rnw = rnw; de_addr = a; de_nbyte = nb; de_w_data = d;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = de_ack;
    end
    if (!got) check("de_ack_timeout", 32'(de_ack), 32'd1);
    @(posedge clk); #1;
    de_req = 1'b0;
  endtask

  task automatic wr(input logic [17:0] a, input logic [3:0] nb, input logic [31:0] d);
    xfer(1'b0, a, nb, d);
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = idle && !mem_req && (expq.size() == 0);
    end
    check(name, 32'(expq.size()), 32'd0);
  endtask

  task automatic wait_req(input string name, input int lo, input int hi);
    int n = 0;
    bit seen = 0;
    for (int i = 1; i <= hi + 2 && !seen; i++) begin
      @(negedge clk);
      n = i;
      seen = mem_req;
    end
    check(name, 32'(seen && n >= lo && n <= hi), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; n_rdack = 0;
    rst_n = 1'b0; ack_en = 1'b1; flush = 1'b0;
    de_req = 1'b0; de_rnw = 1'b0; de_addr = '0; de_nbyte = '1; de_w_data = '0;
    repeat (3) @(negedge clk);
    check("rst_de_ack", 32'(de_ack), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_nbyte", 32'(mem_nbyte), 32'hF);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_de_r_data", de_r_data, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Full word assembled from four byte writes.
    expect_wr(18'h00100, 4'b0000, 32'hA5A5A5A5);
    wr(18'h00100, 4'b1110, 32'hA5A5A5A5);
    wr(18'h00100, 4'b1101, 32'hA5A5A5A5);
    wr(18'h00100, 4'b1011, 32'hA5A5A5A5);
    wr(18'h00100, 4'b0111, 32'hA5A5A5A5);
    wait_drain("merge4_drain");

    // Different words stay separate and ordered.
    expect_wr(18'h00010, 4'b1110, 32'h00000022);
    expect_wr(18'h00011, 4'b1110, 32'h00000033);
    wr(18'h00010, 4'b1110, 32'h00000022);
    wr(18'h00011, 4'b1110, 32'h00000033);
    wait_drain("split_drain");

    // Byte-lane merge and same-byte overwrite.
    expect_wr(18'h00600, 4'b1100, 32'h11112211);
    wr(18'h00600, 4'b1110, 32'h11111111);
    wr(18'h00600, 4'b1101, 32'h22222222);
    wait_drain("lane_merge_drain");
    expect_wr(18'h00500, 4'b1110, 32'h000000BB);
    wr(18'h00500, 4'b1110, 32'h000000AA);
    wr(18'h00500, 4'b1110, 32'h000000BB);
    wait_drain("overwrite_drain");

    // Timeout retirement of a lone partial word.
    expect_wr(18'h00200, 4'b1011, 32'h00CC0000);
    wr(18'h00200, 4'b1011, 32'h00CC0000);
    wait_req("timeout_req_window", 15, 18);
    wait_drain("timeout_drain");

    // Flush retires the partial word promptly.
    flush = 1'b1;
    expect_wr(18'h00400, 4'b0111, 32'hCAFE0000);
    wr(18'h00400, 4'b0111, 32'hCAFE0000);
    wait_req("flush_req_window", 1, 3);
    flush = 1'b0;
    wait_drain("flush_drain");

    // Backpressure: FIFO full plus combiner occupied blocks a sixth distinct word.
    ack_en = 1'b0;
    for (int i = 0; i < 6; i++) expect_wr(18'h01000 + 18'(i), 4'b1100, 32'(i + 1));
    for (int i = 0; i < 5; i++) wr(18'h01000 + 18'(i), 4'b1100, 32'(i + 1));
    de_req = 1'b1; de_rnw = 1'b0; de_addr = 18'h01005; de_nbyte = 4'b1100; de_w_data = 32'd6;
    repeat (4) @(negedge clk);
    check("full_blocks_de_ack", 32'(de_ack), 32'd0);
    ack_en = 1'b1;
    begin
      bit got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        got = de_ack;
      end
      check("sixth_accepted", 32'(got), 32'd1);
      @(posedge clk); #1;
      de_req = 1'b0;
    end
    wait_drain("full_drain");

    // Read after write: write drains to memory before the read is issued.
    expect_wr(18'h00300, 4'b1110, 32'h00000011);
    begin
      mtx_t t;
      t.rnw = 1'b1; t.addr = 18'h00300; t.nbyte = 4'b0000; t.data = '0;
      expq.push_back(t);
    end
    rdq.push_back(32'hDEADBDEF);
    n_rdack = 0;
    wr(18'h00300, 4'b1110, 32'h00000011);
    xfer(1'b1, 18'h00300, 4'b1111, 32'h0);
    repeat (4) @(negedge clk);
    check("read_ack_pulses", 32'(n_rdack), 32'd1);
    check("read_queue_empty", 32'(rdq.size()), 32'd0);
    wait_drain("read_drain");

    // Asynchronous reset with writes still buffered.
    ack_en = 1'b0;
    wr(18'h02000, 4'b1110, 32'h1);
    wr(18'h02001, 4'b1110, 32'h2);
    wr(18'h02002, 4'b1110, 32'h3);
    repeat (2) @(negedge clk);
    check("pre_reset_mem_req", 32'(mem_req), 32'd1);
    expq.delete();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_mem_req", 32'(mem_req), 32'd0);
    check("async_reset_mem_nbyte", 32'(mem_nbyte), 32'hF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", 32'(idle), 32'd1);
    repeat (40) @(negedge clk);
    check("post_reset_no_req", 32'(mem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
